slip_arbiter: RTL
=================

SLIP_ARBITER -- requirements
Module: slip_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters; legal values 4, 8, 16, 32.
REQ-002 Parameter PTR_W, default 2: pointer width, equal to log2(N).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  N  request vector; bit i set means input i requests this resource.
REQ-006 start  input  1  one-cycle strobe that launches one arbitration round.
REQ-007 first_iter  input  1  sampled with start; set means the round is the first iteration of a scheduling slot.
REQ-008 accept  input  1  one-cycle response: the granted requester took the grant.
REQ-009 reject  input  1  one-cycle response: the granted requester declined the grant.
REQ-010 grant  output  N  registered one-hot grant; all zeros when not valid.
REQ-011 grant_valid  output  1  registered; high while a grant awaits a response.
REQ-012 ptr  output  PTR_W  registered round-robin pointer, i.e. the highest-priority index.
REQ-013 busy  output  1  registered; high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, ARB, WAIT_RSP.
REQ-015 IDLE: start=1 with req nonzero -> ARB; req is latched and first_iter is latched as iter_q.
REQ-016 IDLE: start=1 with req==0 -> stay in IDLE; no grant is issued and ptr is unchanged.
REQ-017 ARB (one cycle): winner = first set bit of the latched req, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1; grant = one-hot(winner); grant_valid=1; -> WAIT_RSP.
REQ-018 Latency: grant_valid SHALL rise exactly 2 clocks after the start edge.
REQ-019 WAIT_RSP: grant and grant_valid are held stable until accept or reject is seen.
REQ-020 WAIT_RSP: accept=1 -> if iter_q=1, ptr = (winner+1) mod N; if iter_q=0, ptr is unchanged; grant clears, grant_valid=0, -> IDLE.
REQ-021 WAIT_RSP: reject=1 and accept=0 -> ptr is unchanged; grant clears; -> IDLE.
REQ-022 Simultaneous accept and reject: accept wins.
REQ-023 start is ignored in ARB and WAIT_RSP; accept and reject are ignored outside WAIT_RSP.
REQ-024 Changes on req after latching SHALL NOT affect the current round.
REQ-025 Pointer wrap: winner=N-1 with an accept in the first iteration -> ptr=0.
REQ-026 The response SHALL have no timeout; the block waits in WAIT_RSP indefinitely.
REQ-027 The back-to-back minimum round is 3 clocks: start, ARB, response; start is accepted again in the cycle after returning to IDLE.

Reset
REQ-028 rst=1 on a clock edge -> state=IDLE, ptr=0, grant=0, grant_valid=0, busy=0, latched req=0, iter_q=0.
REQ-029 rst SHALL override all other inputs in the same cycle, including mid-round in ARB or WAIT_RSP; the pending grant is dropped and ptr is not updated.

Structure
REQ-030 The state encoding enum and the legal-N constants SHALL live in the shared package slip_pkg.
REQ-031 One sub-module, rr_pick, SHALL be purely combinational: inputs req and ptr, output one-hot grant.
REQ-032 rr_pick SHALL be built by rotating req right by ptr, applying a fixed lowest-index-first priority pick, then rotating back left by ptr.
REQ-033 The winner index SHALL be derived from the one-hot grant by an encoder inside slip_arbiter.
REQ-034 rr_pick SHALL contain no latches and SHALL yield all-zeros for req==0.

Verification
REQ-035 N=4, after reset, req=4'b1010, start, first_iter=1 -> grant=4'b0010 two clocks later; accept -> ptr=2.
REQ-036 N=4, ptr=2, req=4'b0011, start, first_iter=1 -> grant=4'b0001 (wrap); accept -> ptr=1.
REQ-037 N=4, ptr=1, req=4'b1110, first_iter=0 -> grant=4'b0010; accept -> ptr stays 1; repeat with reject -> ptr stays 1.
REQ-038 N=8, ptr=0, req=8'h80, first_iter=1 -> grant=8'h80; accept -> ptr=0 (wrap from 7).
REQ-039 Corner stimuli:
- accept and reject asserted in the same cycle -> treated as accept.
- start with req=0 -> grant_valid stays 0 and busy stays 0.
- start asserted during WAIT_RSP -> ignored.
REQ-040 Reset asserted during WAIT_RSP with grant=4'b0100 -> next cycle grant=0, grant_valid=0, ptr=0, state IDLE.

Source files
------------

// File: rtl/slip_pkg.sv
// Shared types and constants for the slip arbiter and its round-robin picker.
package slip_pkg;

   // Arbitration round states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARB      = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   // Requester counts the arbiter is built and verified for.
   localparam int LEGAL_N_4  = 4;
   localparam int LEGAL_N_8  = 8;
   localparam int LEGAL_N_16 = 16;
   localparam int LEGAL_N_32 = 32;

   // True when n is one of the supported requester counts.
   function automatic bit isLegalN(input int n);
      return (n == LEGAL_N_4) || (n == LEGAL_N_8) ||
             (n == LEGAL_N_16) || (n == LEGAL_N_32);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req right by ptr, take the lowest set
// bit, rotate the one-hot result back left by ptr. All-zero req gives all-zero grant.
module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   logic [N-1:0] rotReq;
   logic [N-1:0] pick;

   // N is a power of two, so PTR_W-bit index arithmetic wraps modulo N for free.
   always_comb begin
      rotReq = '0;
      grant  = '0;
      for (int i = 0; i < N; i++) begin
         rotReq[i] = req[PTR_W'(i) + ptr];
      end
      pick = rotReq & (~rotReq + N'(1));
      for (int i = 0; i < N; i++) begin
         grant[PTR_W'(i) + ptr] = pick[i];
      end
   end

endmodule

// File: rtl/slip_arbiter.sv
// Round-robin arbiter with iSLIP-style pointer update: the pointer only moves
// past the winner when the grant is accepted in the first iteration of a slot.
module slip_arbiter
   import slip_pkg::*;
#(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             start,
   input  logic             first_iter,
   input  logic             accept,
   input  logic             reject,
   output logic [N-1:0]     grant,
   output logic             grant_valid,
   output logic [PTR_W-1:0] ptr,
   output logic             busy
);

   state_t           state_q;
   logic [N-1:0]     req_q;
   logic             iter_q;
   logic [N-1:0]     grant_q;
   logic             grantValid_q;
   logic [PTR_W-1:0] ptr_q;
   logic             busy_q;

   logic [N-1:0]     pickGrant;
   logic [PTR_W-1:0] winner;
   logic [PTR_W-1:0] ptr_d;

   rr_pick #(
      .N     (N),
      .PTR_W (PTR_W)
   ) uPick (
      .req   (req_q),
      .ptr   (ptr_q),
      .grant (pickGrant)
   );

   // Encode the held one-hot grant back to an index and form the advanced pointer.
   always_comb begin
      winner = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i]) begin
            winner = PTR_W'(i);
         end
      end
      ptr_d = winner + PTR_W'(1);
   end

   // Round FSM: latch the request, issue the grant, then wait for the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         req_q        <= '0;
         iter_q       <= 1'b0;
         grant_q      <= '0;
         grantValid_q <= 1'b0;
         ptr_q        <= '0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && (req != '0)) begin
                  req_q   <= req;
                  iter_q  <= first_iter;
                  state_q <= ARB;
                  busy_q  <= 1'b1;
               end
            end
            ARB: begin
               grant_q      <= pickGrant;
               grantValid_q <= 1'b1;
               state_q      <= WAIT_RSP;
            end
            WAIT_RSP: begin
               if (accept || reject) begin
                  if (accept && iter_q) begin
                     ptr_q <= ptr_d;
                  end
                  grant_q      <= '0;
                  grantValid_q <= 1'b0;
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
               end
            end
            default: begin
               state_q      <= IDLE;
               grant_q      <= '0;
               grantValid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grantValid_q;
   assign ptr         = ptr_q;
   assign busy        = busy_q;

endmodule
